// File: rtl/instr_mem_loader.sv
// Boot loader: packs a byte stream (MSB first) into 32-bit words and writes them to instruction memory.
// Latency: write pulse is registered, appearing the cycle after the 4th byte of a word is accepted.
// Backpressure: none; the byte stream is never stalled, and a byte may land in a write-pulse cycle.
// Optional inter-byte watchdog enabled by defining LOADER_TIMEOUT_EN.
module instr_mem_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_rx_valid,
    input  logic [DATA_WIDTH-1:0]   i_rx_data,
    output logic                    o_write_enable,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH*4-1:0] o_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [ADDR_WIDTH-2:0]   o_word_count,
    output logic                    o_timeout
);
    localparam int WW = DATA_WIDTH * 4;
    localparam int CW = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR} state_t;

    state_t                state_q, state_d;
    state_t                pend_q, pend_d;    // state to take once the pending write retires
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            idx_q, idx_d;
    logic [WW-1:0]         pack_q, pack_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WW-1:0]         wdata_q, wdata_d;
    logic [CW-1:0]         wc_q, wc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [WW-1:0]         word;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    // Word formed by shifting the incoming byte into the packing register.
    assign word = {pack_q[WW-DATA_WIDTH-1:0], i_rx_data};

    // Next-state, packing, write-pulse and bookkeeping logic.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pack_d  = pack_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wc_d    = wc_q;
`ifdef LOADER_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        if (state_q == ST_LOAD) begin
            // Retire the write issued last cycle: count it, advance, or leave LOAD.
            if (we_q) begin
                wc_d    = wc_q + CW'(1);
                state_d = pend_q;
                if (pend_q == ST_LOAD) begin
                    addr_d = addr_q + ADDR_WIDTH'(4);
                end
            end
            if (i_rx_valid) begin
                pack_d = word;
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = word;
                    if (word == {WW{1'b1}}) begin
                        pend_d = ST_DONE;
                    end else if (addr_q == LAST_ADDR) begin
                        pend_d = ST_ERROR;
                    end else begin
                        pend_d = ST_LOAD;
                    end
                end
            end
`ifdef LOADER_TIMEOUT_EN
            if (i_rx_valid) begin
                cnt_d = '0;
            end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = ST_ERROR;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
`endif
        end else if (i_start) begin
            state_d = ST_LOAD;
            pend_d  = ST_LOAD;
            addr_d  = '0;
            idx_d   = '0;
            wc_d    = '0;
`ifdef LOADER_TIMEOUT_EN
            cnt_d     = '0;
            timeout_d = 1'b0;
`endif
        end
        busy_d  = (state_d == ST_LOAD);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            pend_q  <= ST_LOAD;
            addr_q  <= '0;
            idx_q   <= '0;
            pack_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pack_q  <= pack_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wc_q    <= wc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Watchdog counter and cause flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_write_enable = we_q;
    assign o_addr         = waddr_q;
    assign o_data         = wdata_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
    assign o_word_count   = wc_q;
endmodule
